// File: rtl/microstep_sequencer.sv
// T-state sequencer feeding a 3-to-8 step decoder: step count, decoder enables, halt and early end.
// Optional macro SEQ_SINGLE_STEP_EN adds a synchronised single-step advance source.
module microstep_sequencer #(
  parameter int unsigned LAST_STEP = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       hlt,
  input  logic       step_clr,
  input  logic       resume,
  input  logic       ss_mode,
  input  logic       ss_pulse,
  output logic       step_a,
  output logic       step_b,
  output logic       step_c,
  output logic       dec_g1,
  output logic       dec_g2a,
  output logic       dec_g2b,
  output logic [2:0] step_q,
  output logic       halted,
  output logic       instr_done
);

  // Encoding chosen so bit 0 is "primed" and bit 1 is "halted" directly.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b11
  } state_t;

  localparam logic [2:0] LAST = 3'(LAST_STEP);

  state_t     state_q, state_d;
  logic [2:0] step_d;
  logic       done_q, done_d;
  logic       advance;

`ifdef SEQ_SINGLE_STEP_EN
  logic ss_s1, ss_s2, ss_dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_s1  <= 1'b0;
      ss_s2  <= 1'b0;
      ss_dly <= 1'b0;
    end else begin
      ss_s1  <= ss_pulse;
      ss_s2  <= ss_s1;
      ss_dly <= ss_s2;
    end
  end

  // In single-step mode only a synchronised rising edge of ss_pulse advances.
  assign advance = ss_mode ? (ss_s2 & ~ss_dly) : clk_en;
`else
  logic unused_ss;
  assign unused_ss = ss_mode ^ ss_pulse;
  assign advance   = clk_en;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (advance) state_d = RUN;
      end
      RUN: begin
        if (advance) begin
          // Halt outranks an early end in the same cycle.
          if (hlt) begin
            state_d = HALT;
          end else if (step_clr || step_q == LAST) begin
            step_d = 3'd0;
            done_d = 1'b1;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      HALT: begin
        if (resume) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  assign halted     = state_q[1];
  assign dec_g1     = ~state_q[1];
  assign dec_g2a    = state_q[1];
  assign dec_g2b    = ~state_q[0];
  assign instr_done = done_q;
  assign step_a     = step_q[2];
  assign step_b     = step_q[1];
  assign step_c     = step_q[0];

endmodule

// File: tb/tb_microstep_sequencer.sv
// Bench for microstep_sequencer: two instances (LAST_STEP=5 and 2) on shared stimulus,
// checked cycle by cycle against a behavioural model through expected-value queues.
module tb_microstep_sequencer;

  localparam int W = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b0, hlt = 1'b0, step_clr = 1'b0, resume = 1'b0;
  logic ss_mode = 1'b0, ss_pulse = 1'b0;

  logic       a1, b1, c1, g1_1, g2a_1, g2b_1, halted1, done1;
  logic [2:0] step1;
  logic       a2, b2, c2, g1_2, g2a_2, g2b_2, halted2, done2;
  logic [2:0] step2;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp2_q[$];

  // Behavioural model state: mode 0=idle, 1=run, 2=halt.
  int   m_mode[2];
  int   m_step[2];
  bit   m_done[2];
  int   m_last[2] = '{5, 2};
  bit   p1, p2, p3;

  always #5 clk = ~clk;

  microstep_sequencer u_dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .hlt(hlt), .step_clr(step_clr),
    .resume(resume), .ss_mode(ss_mode), .ss_pulse(ss_pulse),
    .step_a(a1), .step_b(b1), .step_c(c1), .dec_g1(g1_1), .dec_g2a(g2a_1),
    .dec_g2b(g2b_1), .step_q(step1), .halted(halted1), .instr_done(done1)
  );

  microstep_sequencer #(.LAST_STEP(2)) u_dut2 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .hlt(hlt), .step_clr(step_clr),
    .resume(resume), .ss_mode(ss_mode), .ss_pulse(ss_pulse),
    .step_a(a2), .step_b(b2), .step_c(c2), .dec_g1(g1_2), .dec_g2a(g2a_2),
    .dec_g2b(g2b_2), .step_q(step2), .halted(halted2), .instr_done(done2)
  );

  function automatic logic [W-1:0] exp_vec(int m);
    logic [2:0] s;
    bit h;
    s = 3'(m_step[m]);
    h = (m_mode[m] == 2);
    return {s, s, h, m_done[m], ~h, h, (m_mode[m] == 0)};
  endfunction

  // Apply one cycle of inputs and predict the state after the coming rising edge.
  task automatic drive(input bit r, input bit ce, input bit h, input bit sc,
                       input bit rs, input bit sm, input bit sp);
    bit adv;
    @(negedge clk);
    rst = r; clk_en = ce; hlt = h; step_clr = sc; resume = rs;
    ss_mode = sm; ss_pulse = sp;
    adv = ce;
`ifdef SEQ_SINGLE_STEP_EN
    // ss_pulse reaches the sequencer as a rising edge seen two samples late.
    if (sm) adv = p2 & ~p3;
`endif
    for (int m = 0; m < 2; m++) begin
      if (r) begin
        m_mode[m] = 0; m_step[m] = 0; m_done[m] = 0;
      end else begin
        m_done[m] = 0;
        if (m_mode[m] == 0) begin
          if (adv) m_mode[m] = 1;
        end else if (m_mode[m] == 1) begin
          if (adv) begin
            if (h) m_mode[m] = 2;
            else if (sc || m_step[m] == m_last[m]) begin
              m_step[m] = 0; m_done[m] = 1;
            end else m_step[m] = m_step[m] + 1;
          end
        end else if (rs) m_mode[m] = 1;
      end
    end
    if (r) begin
      p1 = 0; p2 = 0; p3 = 0;
    end else begin
      p3 = p2; p2 = p1; p1 = sp;
    end
    exp_q.push_back(exp_vec(0));
    exp2_q.push_back(exp_vec(1));
  endtask

  task automatic run_en(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    logic [W-1:0] e, act;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {step1, a1, b1, c1, halted1, done1, g1_1, g2a_1, g2b_1};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL seq_last5 t=%0t actual=%b expected=%b", $time, act, e);
      end
    end
    if (exp2_q.size() > 0) begin
      e = exp2_q.pop_front();
      act = {step2, a2, b2, c2, halted2, done2, g1_2, g2a_2, g2b_2};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL seq_last2 t=%0t actual=%b expected=%b", $time, act, e);
      end
    end
  end

  initial begin
    bit sm, sp;
    // Reset, then free-running clk_en through a full wrap.
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 1, 1, 0, 0);
    run_en(9);
    // Early end at step 2.
    drive(1, 0, 0, 0, 0, 0, 0);
    run_en(3);
    drive(0, 1, 0, 1, 0, 0, 0);
    run_en(3);
    // Halt at step 3, hold 10 cycles with noise, resume, continue.
    drive(1, 0, 0, 0, 0, 0, 0);
    run_en(4);
    drive(0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, i % 2, i % 3 == 0, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    run_en(2);
    // Halt and early end together at step 1, then reset mid-halt.
    drive(1, 0, 0, 0, 0, 0, 0);
    run_en(2);
    drive(0, 1, 1, 1, 0, 0, 0);
    run_en(3);
    drive(1, 1, 1, 0, 1, 0, 0);
    // clk_en on alternate cycles.
    for (int i = 0; i < 14; i++) drive(0, i % 2, 0, 0, 0, 0, 0);
    // Single-step mode: three ss_pulse rises with clk_en held high.
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 1, 1);
      for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 1, 0);
    end
    // Randomised traffic.
    drive(1, 0, 0, 0, 0, 0, 0);
    sm = 0; sp = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 49) == 0) sm = ~sm;
      if ($urandom_range(0, 3) == 0) sp = ~sp;
      drive($urandom_range(0, 119) == 0, $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 4) == 0, sm, sp);
    end
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d/%0d pending required=0/0", exp_q.size(), exp2_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/microstep_sequencer.md
# microstep_sequencer

Microstep (T-state) sequencer for the 8-bit CPU control unit. It sits directly upstream of the 3-to-8 step decoder: it generates the 3-bit step number and the decoder's three enable pins, and it handles halt, early end-of-instruction and reset. The decoded active-low step lines then index the control-word logic.

## Interface
Parameters:
- LAST_STEP, 5, highest step index before wrap to 0 (legal 1..7); default gives T0..T5.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  advance qualifier from the CPU clock divider; state moves only in cycles where it is 1 (except reset and resume).
- hlt  in  1  halt request from the control word; sampled when clk_en=1.
- step_clr  in  1  early end-of-instruction request from the control word; sampled when clk_en=1.
- resume  in  1  leave HALT; sampled every cycle.
- ss_mode  in  1  single-step mode select (see Configuration).
- ss_pulse  in  1  single-step request (see Configuration).
- step_a  out  1  decoder select MSB (step_q[2]).
- step_b  out  1  decoder select (step_q[1]).
- step_c  out  1  decoder select LSB (step_q[0]).
- dec_g1  out  1  decoder active-high enable.
- dec_g2a  out  1  decoder active-low enable.
- dec_g2b  out  1  decoder active-low enable.
- step_q  out  3  current step number.
- halted  out  1  1 while in HALT.
- instr_done  out  1  one-cycle pulse when the step returns to 0.

## Operation
- Registers: step_q[2:0], halted, primed, instr_done.
- States: IDLE (primed=0), RUN (primed=1, halted=0), HALT (halted=1).
- IDLE: after reset. The decoder is disabled. The first advance event moves to RUN; step_q stays 0.
- RUN, on an advance event, the first matching rule applies:
  - hlt=1 -> HALT; step_q holds.
  - step_clr=1 or step_q==LAST_STEP -> step_q=0; instr_done=1 for the next cycle.
  - otherwise step_q=step_q+1.
- HALT:
  - step_q is frozen. clk_en, hlt and step_clr are ignored.
  - resume=1 -> RUN the next cycle with step_q unchanged. The next advance event continues counting from that value.
- Advance event: clk_en=1, or the single-step qualifier when the macro is enabled.
- Decoder enables are driven from flops only:
  - dec_g1 = ~halted.
  - dec_g2a = halted.
  - dec_g2b = ~primed.
  - Result: all eight decoder outputs are high (no control line asserted) in IDLE and HALT.
- step_q never exceeds LAST_STEP. Wrap is an explicit compare, not a 3-bit overflow, except when LAST_STEP=7, where both coincide.

## Timing
- Reset (rst=1 at an edge): step_q=0, halted=0, primed=0, instr_done=0. Outputs are therefore: step_a/b/c=0, dec_g1=1, dec_g2a=0, dec_g2b=1, halted=0, instr_done=0.
- rst has priority over all inputs, including mid-HALT and mid-instruction.
- Latency: an advance event at edge N updates step_q at edge N. Selects and enables are valid one cycle before the next advance.
- There is no combinational path from any input to any output.
- instr_done is high for exactly one clk cycle, coincident with the first cycle of step_q=0. It does not assert when leaving IDLE.
- Simultaneous events:
  - hlt and step_clr together: halt wins, the step holds, no instr_done.
  - resume and hlt in HALT: leave HALT. hlt is ignored in HALT.
  - rst with anything: reset.
- clk_en=0 in RUN: hold all state, with instr_done cleared after its one cycle.

## Configuration
- Macro SEQ_SINGLE_STEP_EN.
- Defined:
  - ss_pulse passes through a 2-flop synchroniser plus an edge detector.
  - When ss_mode=1, the advance event is one cycle per ss_pulse rising edge (clk_en is ignored).
  - When ss_mode=0, the advance event is clk_en.
  - Latency from an ss_pulse rise to the step change is 3 cycles.
- Undefined: ss_mode and ss_pulse are present but ignored, the advance event is clk_en only, and no synchroniser flops exist.

## Test plan
- Reset then clk_en=1 continuously -> cycle 1: step_q stays 0, dec_g2b goes 0; then step_q goes 1,2,3,4,5,0. instr_done pulses once at the wrap, and the decoder sees a={step_q[2]}.
- Hold clk_en=1, assert step_clr at step_q=2 -> step_q=0 next edge; instr_done=1 for one cycle.
- Assert hlt at step_q=3 -> halted=1, dec_g1=0, dec_g2a=1, step_q=3 held for 10 cycles. Then resume=1 -> halted=0 next cycle; the next clk_en gives step_q=4.
- hlt and step_clr together at step_q=1 -> HALT with step_q=1 and no instr_done. Then rst=1 -> step_q=0, halted=0, dec_g2b=1.
- LAST_STEP=2 with clk_en toggling every other cycle -> sequence 0,1,2,0. The step holds in the cycles where clk_en=0.
- With SEQ_SINGLE_STEP_EN, ss_mode=1, clk_en=1: three ss_pulse rises -> exactly three increments, each 3 cycles after its edge. Without the macro, the same stimulus -> free-running count.
